// File: rtl/isp_param_fetch_pkg.sv
// Shared PVR definitions for the ISP parameter fetcher: widths, record slot
// indices and the fetch FSM state encoding.
package isp_param_fetch_pkg;

    localparam int ADDR_W    = 22;
    localparam int SKIP_W    = 3;
    localparam int REC_WORDS = 12;
    localparam int IDX_W     = 4;

    // Record slot indices, in output-port order
    localparam logic [IDX_W-1:0] IDX_ISP = 4'd0;
    localparam logic [IDX_W-1:0] IDX_TSP = 4'd1;
    localparam logic [IDX_W-1:0] IDX_TCW = 4'd2;
    localparam logic [IDX_W-1:0] IDX_VAX = 4'd3;
    localparam logic [IDX_W-1:0] IDX_VAY = 4'd4;
    localparam logic [IDX_W-1:0] IDX_VAZ = 4'd5;
    localparam logic [IDX_W-1:0] IDX_VBX = 4'd6;
    localparam logic [IDX_W-1:0] IDX_VBY = 4'd7;
    localparam logic [IDX_W-1:0] IDX_VBZ = 4'd8;
    localparam logic [IDX_W-1:0] IDX_VCX = 4'd9;
    localparam logic [IDX_W-1:0] IDX_VCY = 4'd10;
    localparam logic [IDX_W-1:0] IDX_VCZ = 4'd11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_STEP = 3'd3,
        ST_OUT  = 3'd4
    } state_e;

    // Vertex A and B Z words are followed by the per-vertex skip words; the
    // vertex C Z word ends the record, so its skip is never applied.
    function automatic logic is_skip_z(input logic [IDX_W-1:0] idx);
        return (idx == IDX_VAZ) || (idx == IDX_VBZ);
    endfunction

endpackage

// File: rtl/isp_param_fetch.sv
// Polygon parameter fetcher: reads the 12 words of one triangle (3 headers,
// X/Y/Z of three vertices) from the parameter cache, one outstanding read at
// a time, then offers the complete record to the rasterizer.
module isp_param_fetch #(
    parameter int ADDR_W = isp_param_fetch_pkg::ADDR_W,
    parameter int SKIP_W = isp_param_fetch_pkg::SKIP_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] poly_addr,
    input  logic [SKIP_W-1:0] skip,
    output logic              busy,
    output logic [ADDR_W-1:0] param_req_addr,
    output logic              param_read,
    input  logic [31:0]       param_dout,
    input  logic              param_data_ready,
    output logic              poly_valid,
    input  logic              poly_ready,
    output logic [31:0]       isp_inst,
    output logic [31:0]       tsp_inst,
    output logic [31:0]       tcw,
    output logic [31:0]       va_x,
    output logic [31:0]       va_y,
    output logic [31:0]       va_z,
    output logic [31:0]       vb_x,
    output logic [31:0]       vb_y,
    output logic [31:0]       vb_z,
    output logic [31:0]       vc_x,
    output logic [31:0]       vc_y,
    output logic [31:0]       vc_z
);

    import isp_param_fetch_pkg::*;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q,  addr_d;
    logic [SKIP_W-1:0]  skip_q,  skip_d;
    logic [IDX_W-1:0]   idx_q,   idx_d;
    logic [31:0]        rec_q [REC_WORDS];

    // Next-state and datapath update for the fetch sequence
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // through the case can leave it unassigned and infer a latch.
        state_d = state_q;
        addr_d  = addr_q;
        skip_d  = skip_q;
        idx_d   = idx_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d  = poly_addr;
                    skip_d  = skip;
                    idx_d   = '0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (param_data_ready) begin
                    state_d = ST_STEP;
                end
            end
            ST_STEP: begin
                if (idx_q == IDX_VCZ) begin
                    state_d = ST_OUT;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    addr_d  = is_skip_z(idx_q)
                            ? addr_q + ADDR_W'(skip_q) + ADDR_W'(1)
                            : addr_q + ADDR_W'(1);
                    state_d = ST_REQ;
                end
            end
            ST_OUT: begin
                if (poly_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state plus address/index/skip registers
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            skip_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            skip_q  <= skip_d;
            idx_q   <= idx_d;
        end
    end

    // Record capture: only a data_ready seen in WAIT writes the current slot
    always_ff @(posedge clock) begin
        // NOTE: the record array is reset explicitly because a reset must
        // drop any partial polygon and drive all record outputs to zero.
        if (reset) begin
            for (int i = 0; i < REC_WORDS; i++) begin
                rec_q[i] <= '0;
            end
        end else if (state_q == ST_WAIT && param_data_ready) begin
            rec_q[idx_q] <= param_dout;
        end
    end

    // Handshake outputs decoded from state
    always_comb begin
        busy           = (state_q != ST_IDLE);
        param_read     = (state_q == ST_REQ);
        poly_valid     = (state_q == ST_OUT);
        param_req_addr = addr_q;
    end

    assign isp_inst = rec_q[IDX_ISP];
    assign tsp_inst = rec_q[IDX_TSP];
    assign tcw      = rec_q[IDX_TCW];
    assign va_x     = rec_q[IDX_VAX];
    assign va_y     = rec_q[IDX_VAY];
    assign va_z     = rec_q[IDX_VAZ];
    assign vb_x     = rec_q[IDX_VBX];
    assign vb_y     = rec_q[IDX_VBY];
    assign vb_z     = rec_q[IDX_VBZ];
    assign vc_x     = rec_q[IDX_VCX];
    assign vc_y     = rec_q[IDX_VCY];
    assign vc_z     = rec_q[IDX_VCZ];

endmodule

// File: tb/tb_isp_param_fetch.sv
// Directed bench for isp_param_fetch with a fixed-latency parameter cache model.
module tb_isp_param_fetch;

    localparam int ADDR_W = 22;
    localparam int SKIP_W = 3;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] poly_addr = '0;
    logic [SKIP_W-1:0] skip = '0;
    logic              busy;
    logic [ADDR_W-1:0] param_req_addr;
    logic              param_read;
    logic [31:0]       param_dout;
    logic              param_data_ready;
    logic              poly_valid;
    logic              poly_ready = 1'b0;
    logic [31:0]       isp_inst, tsp_inst, tcw;
    logic [31:0]       va_x, va_y, va_z, vb_x, vb_y, vb_z, vc_x, vc_y, vc_z;

    int checks = 0;
    int errors = 0;

    isp_param_fetch #(.ADDR_W(ADDR_W), .SKIP_W(SKIP_W)) dut (
        .clock(clock), .reset(reset), .start(start), .poly_addr(poly_addr),
        .skip(skip), .busy(busy), .param_req_addr(param_req_addr),
        .param_read(param_read), .param_dout(param_dout),
        .param_data_ready(param_data_ready), .poly_valid(poly_valid),
        .poly_ready(poly_ready), .isp_inst(isp_inst), .tsp_inst(tsp_inst),
        .tcw(tcw), .va_x(va_x), .va_y(va_y), .va_z(va_z), .vb_x(vb_x),
        .vb_y(vb_y), .vb_z(vb_z), .vc_x(vc_x), .vc_y(vc_y), .vc_z(vc_z)
    );

    always #5 clock = ~clock;

    // Record outputs gathered in slot order
    logic [31:0] rec_out [12];
    always_comb begin
        rec_out[0]  = isp_inst; rec_out[1]  = tsp_inst; rec_out[2]  = tcw;
        rec_out[3]  = va_x;     rec_out[4]  = va_y;     rec_out[5]  = va_z;
        rec_out[6]  = vb_x;     rec_out[7]  = vb_y;     rec_out[8]  = vb_z;
        rec_out[9]  = vc_x;     rec_out[10] = vc_y;     rec_out[11] = vc_z;
    end

    function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
        return 32'hA000_0000 + 32'(a);
    endfunction

    function automatic logic [ADDR_W-1:0] exp_addr(input logic [ADDR_W-1:0] base,
                                                   input int sk, input int k);
        int off;
        off = k + ((k >= 6) ? sk : 0) + ((k >= 9) ? sk : 0);
        return base + ADDR_W'(off);
    endfunction

    // Cache model: logs every strobe, answers one read after a fixed latency
    int                lat = 3;
    logic              pend = 1'b0;
    int                cnt = 0;
    logic [ADDR_W-1:0] paddr = '0;
    logic              mdl_ready = 1'b0;
    logic [31:0]       mdl_dout = '0;
    logic              inj_ready = 1'b0;
    logic [ADDR_W-1:0] req_log [$];
    int                strobes = 0;

    assign param_data_ready = mdl_ready | inj_ready;
    assign param_dout       = inj_ready ? 32'hDEAD_BEEF : mdl_dout;

    always @(negedge clock) begin
        mdl_ready = 1'b0;
        if (reset) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                if (cnt <= 1) begin
                    mdl_ready = 1'b1;
                    mdl_dout  = mem_word(paddr);
                    pend      = 1'b0;
                end else begin
                    cnt--;
                end
            end
            if (param_read) begin
                strobes++;
                req_log.push_back(param_req_addr);
                if (!pend && !mdl_ready) begin
                    pend  = 1'b1;
                    cnt   = lat;
                    paddr = param_req_addr;
                end
            end
        end
    end

    logic [31:0] exp_rec [12];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start(input logic [ADDR_W-1:0] a, input int sk);
        poly_addr = a;
        skip      = SKIP_W'(sk);
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 2000; i++) begin
            if (poly_valid) begin
                return;
            end
            tick();
        end
        checks++;
        errors++;
        $display("FAIL %s_timeout: poly_valid=%b required 1 within 2000 cycles", name, poly_valid);
    endtask

    task automatic check_result(input string name, input logic [ADDR_W-1:0] base, input int sk);
        checks++;
        if (strobes !== 12) begin
            errors++;
            $display("FAIL %s_strobes: got %0d required 12", name, strobes);
        end
        for (int k = 0; k < 12; k++) begin
            exp_rec[k] = mem_word(exp_addr(base, sk, k));
            if (k < req_log.size()) begin
                checks++;
                if (req_log[k] !== exp_addr(base, sk, k)) begin
                    errors++;
                    $display("FAIL %s_addr[%0d]: got %h required %h", name, k, req_log[k], exp_addr(base, sk, k));
                end
            end
            checks++;
            if (rec_out[k] !== exp_rec[k]) begin
                errors++;
                $display("FAIL %s_word[%0d]: got %h required %h", name, k, rec_out[k], exp_rec[k]);
            end
        end
    endtask

    task automatic fetch(input string name, input logic [ADDR_W-1:0] base, input int sk);
        req_log.delete();
        strobes = 0;
        pulse_start(base, sk);
        wait_valid(name);
        check_result(name, base, sk);
    endtask

    task automatic accept(input string name);
        poly_ready = 1'b1;
        tick();
        poly_ready = 1'b0;
        checks++;
        if (poly_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_accept: poly_valid=%b busy=%b required 0 0", name, poly_valid, busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || param_read !== 1'b0 || poly_valid !== 1'b0 || param_req_addr !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: busy=%b read=%b valid=%b addr=%h required 0 0 0 0",
                     busy, param_read, poly_valid, param_req_addr);
        end
        for (int k = 0; k < 12; k++) begin
            checks++;
            if (rec_out[k] !== 32'h0) begin
                errors++;
                $display("FAIL reset_word[%0d]: got %h required 00000000", k, rec_out[k]);
            end
        end
    endtask

    task automatic test_skip0();
        fetch("skip0", 22'h000100, 0);
        accept("skip0");
    endtask

    task automatic test_skip2();
        fetch("skip2", 22'h000200, 2);
        accept("skip2");
    endtask

    task automatic test_wrap();
        fetch("wrap", 22'h3FFFFE, 0);
        accept("wrap");
    endtask

    task automatic test_hold();
        int bad;
        fetch("hold", 22'h000300, 1);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 3 || i == 11) begin
                poly_addr = 22'h001000;
                start     = 1'b1;
            end else begin
                start     = 1'b0;
            end
            tick();
            if (poly_valid !== 1'b1) bad++;
            for (int k = 0; k < 12; k++) begin
                if (rec_out[k] !== exp_rec[k]) bad++;
            end
        end
        start = 1'b0;
        checks++;
        if (bad !== 0 || strobes !== 12) begin
            errors++;
            $display("FAIL hold_stable: unstable samples=%0d strobes=%0d required 0 12", bad, strobes);
        end
        poly_ready = 1'b1;
        tick();
        poly_ready = 1'b0;
        checks++;
        if (poly_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_deassert: poly_valid=%b required 0", poly_valid);
        end
        req_log.delete();
        strobes = 0;
        pulse_start(22'h000400, 0);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL hold_restart: busy=%b required 1", busy);
        end
        wait_valid("hold_restart");
        check_result("hold_restart", 22'h000400, 0);
        accept("hold_restart");
    endtask

    task automatic test_reset_mid();
        req_log.delete();
        strobes = 0;
        pulse_start(22'h000500, 1);
        for (int i = 0; i < 500 && strobes < 7; i++) begin
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || param_read !== 1'b0 || poly_valid !== 1'b0 || strobes !== 7) begin
            errors++;
            $display("FAIL midreset_ctrl: busy=%b read=%b valid=%b strobes=%0d required 0 0 0 7",
                     busy, param_read, poly_valid, strobes);
        end
        for (int k = 0; k < 12; k++) begin
            checks++;
            if (rec_out[k] !== 32'h0) begin
                errors++;
                $display("FAIL midreset_word[%0d]: got %h required 00000000", k, rec_out[k]);
            end
        end
        tick();
        fetch("after_reset", 22'h000600, 3);
        accept("after_reset");
    endtask

    task automatic test_spurious();
        fetch("spur_base", 22'h000700, 0);
        accept("spur_base");
        inj_ready = 1'b1;
        tick();
        inj_ready = 1'b0;
        checks++;
        if (busy !== 1'b0 || rec_out[0] !== exp_rec[0]) begin
            errors++;
            $display("FAIL spur_idle: busy=%b isp=%h required 0 %h", busy, rec_out[0], exp_rec[0]);
        end
        req_log.delete();
        strobes = 0;
        pulse_start(22'h000800, 0);
        checks++;
        if (param_read !== 1'b1 || param_req_addr !== 22'h000800) begin
            errors++;
            $display("FAIL spur_req_state: read=%b addr=%h required 1 000800", param_read, param_req_addr);
        end
        inj_ready = 1'b1;
        tick();
        inj_ready = 1'b0;
        checks++;
        if (busy !== 1'b1 || rec_out[0] !== exp_rec[0]) begin
            errors++;
            $display("FAIL spur_req: busy=%b isp=%h required 1 %h", busy, rec_out[0], exp_rec[0]);
        end
        wait_valid("spur_fetch");
        check_result("spur_fetch", 22'h000800, 0);
        accept("spur_fetch");
    endtask

    initial begin
        test_reset();
        test_skip0();
        test_skip2();
        test_wrap();
        test_hold();
        test_reset_mid();
        test_spurious();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
